// File: rtl/pmp_csr_pkg.sv
// Shared constants and types for the PMP CSR bank: cfg byte layout, address
// matching modes, CSR operation encodings and privilege levels.
package pmp_csr_pkg;

    localparam int          pmp_regions  = 16;
    localparam logic [11:0] csr_pmpcfg0  = 12'h3A0;
    localparam logic [11:0] csr_pmpaddr0 = 12'h3B0;

    localparam logic [1:0] u_mode = 2'b00;
    localparam logic [1:0] s_mode = 2'b01;
    localparam logic [1:0] m_mode = 2'b11;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    typedef enum logic [1:0] {
        CSR_READ = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_type;

    typedef struct packed {
        logic        csr_valid;
        logic [11:0] csr_addr;
        csr_op_e     csr_op;
        logic [31:0] csr_wdata;
        logic [1:0]  priv_mode;
    } pmp_csr_in_type;

    typedef struct packed {
        logic [31:0] csr_rdata;
        logic        csr_rvalid;
        logic        csr_hit;
        logic        csr_illegal;
    } pmp_csr_out_type;

endpackage

// File: rtl/pmp_cfg_warl.sv
// Combinational legaliser for one pmpcfg byte: a locked entry keeps its value,
// otherwise reserved bits are cleared and the reserved R=0/W=1 pair loses W.
module pmp_cfg_warl
    import pmp_csr_pkg::*;
(
    input  pmpcfg_type i_old,
    input  logic [7:0] i_wdata,
    output pmpcfg_type o_cfg
);

    always_comb begin
        o_cfg = i_old;
        if (!i_old.l) begin
            o_cfg      = pmpcfg_type'(i_wdata);
            o_cfg.rsvd = 2'b00;
            if (!o_cfg.r && o_cfg.w)
                o_cfg.w = 1'b0;
        end
    end

endmodule

// File: rtl/pmp_csr.sv
// Machine-mode PMP CSR bank (pmpcfg0..3, pmpaddr0..15) with WARL/lock handling,
// registered read data and direct per-region cfg/addr outputs for the checker.
module pmp_csr
    import pmp_csr_pkg::*;
#(
    parameter int PMP_REGIONS = pmp_regions
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_csr_valid,
    input  logic [11:0]                   i_csr_addr,
    input  logic [1:0]                    i_csr_op,
    input  logic [31:0]                   i_csr_wdata,
    input  logic [1:0]                    i_priv_mode,
    output logic [31:0]                   o_csr_rdata,
    output logic                          o_csr_rvalid,
    output logic                          o_csr_hit,
    output logic                          o_csr_illegal,
    output pmpcfg_type [PMP_REGIONS-1:0]  o_pmpcfg,
    output logic [PMP_REGIONS-1:0][31:0]  o_pmpaddr
);

    localparam logic [4:0] NREG = 5'(PMP_REGIONS);

    pmpcfg_type  r_cfg  [16];
    logic [31:0] r_addr [16];
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_hit;
    logic        r_illegal;

    logic        w_cfg_sel;
    logic        w_addr_sel;
    logic        w_hit;
    logic        w_m;
    logic        w_wr;
    logic [3:0]  w_idx;
    logic [3:0]  w_idx_nx;
    logic        w_idx_ok;
    logic        w_addr_lock;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic [3:0]  w_ridx [4];
    pmpcfg_type  w_warl [4];

    assign w_cfg_sel  = (i_csr_addr[11:2] == csr_pmpcfg0[11:2]);
    assign w_addr_sel = (i_csr_addr[11:4] == csr_pmpaddr0[11:4]);
    assign w_hit      = w_cfg_sel || w_addr_sel;
    assign w_m        = (i_priv_mode == m_mode);
    assign w_idx      = i_csr_addr[3:0];
    assign w_idx_nx   = w_idx + 4'd1;
    assign w_idx_ok   = ({1'b0, w_idx} < NREG);

    // Set/clear with a zero operand is a pure read and must not touch state.
    assign w_wr = i_csr_valid && w_hit && w_m && (i_csr_op != CSR_READ) &&
                  !((i_csr_op != CSR_RW) && (i_csr_wdata == 32'd0));

    // An entry is also frozen when the next entry is a locked TOR top bound.
    assign w_addr_lock = r_cfg[w_idx].l ||
                         ((({1'b0, w_idx} + 5'd1) < NREG) &&
                          r_cfg[w_idx_nx].l && (r_cfg[w_idx_nx].a == A_TOR));

    // Unimplemented entries are never written, so they read back as zero.
    always_comb begin
        w_old = '0;
        if (w_cfg_sel) begin
            for (int k = 0; k < 4; k++)
                w_old[8*k +: 8] = r_cfg[w_ridx[k]];
        end else if (w_addr_sel) begin
            w_old = r_addr[w_idx];
        end
    end

    always_comb begin
        w_new = w_old;
        case (i_csr_op)
            CSR_RW:  w_new = i_csr_wdata;
            CSR_RS:  w_new = w_old | i_csr_wdata;
            CSR_RC:  w_new = w_old & ~i_csr_wdata;
            default: w_new = w_old;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_warl
        assign w_ridx[g] = {i_csr_addr[1:0], 2'(g)};
        pmp_cfg_warl u_warl (
            .i_old   (r_cfg[w_ridx[g]]),
            .i_wdata (w_new[8*g +: 8]),
            .o_cfg   (w_warl[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < 16; i++) begin
                r_cfg[i]  <= '0;
                r_addr[i] <= '0;
            end
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_hit     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_rvalid  <= i_csr_valid;
            r_hit     <= i_csr_valid && w_hit;
            r_illegal <= i_csr_valid && w_hit && !w_m;
            if (i_csr_valid)
                r_rdata <= (w_hit && w_m) ? w_old : 32'd0;
            if (w_wr && w_cfg_sel) begin
                for (int k = 0; k < 4; k++)
                    if ({1'b0, w_ridx[k]} < NREG)
                        r_cfg[w_ridx[k]] <= w_warl[k];
            end
            if (w_wr && w_addr_sel && w_idx_ok && !w_addr_lock)
                r_addr[w_idx] <= w_new;
        end
    end

    for (genvar g = 0; g < PMP_REGIONS; g++) begin : g_out
        assign o_pmpcfg[g]  = r_cfg[g];
        assign o_pmpaddr[g] = r_addr[g];
    end

    assign o_csr_rdata   = r_rdata;
    assign o_csr_rvalid  = r_rvalid;
    assign o_csr_hit     = r_hit;
    assign o_csr_illegal = r_illegal;

endmodule

// File: tb/tb_pmp_csr.sv
// Self-checking bench for pmp_csr: directed scenarios plus randomized accesses
// against a behavioural model, on a 16-region and an 8-region instance.
module tb_pmp_csr;
    import pmp_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] addr = '0;
    logic [1:0]  op = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  priv = m_mode;

    logic [31:0]       rdata16, rdata8;
    logic              rvalid16, rvalid8, hit16, hit8, ill16, ill8;
    logic [15:0][7:0]  cfg16;
    logic [7:0][7:0]   cfg8;
    logic [15:0][31:0] paddr16;
    logic [7:0][31:0]  paddr8;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model, [0] = 16 regions, [1] = 8 regions
    logic [7:0]  mcfg  [2][16];
    logic [31:0] maddr [2][16];
    int          nreg  [2] = '{16, 8};

    always #5 clk = ~clk;

    pmp_csr #(.PMP_REGIONS(16)) dut16 (
        .i_clk(clk), .i_rst(rst_n), .i_csr_valid(valid), .i_csr_addr(addr),
        .i_csr_op(op), .i_csr_wdata(wdata), .i_priv_mode(priv),
        .o_csr_rdata(rdata16), .o_csr_rvalid(rvalid16), .o_csr_hit(hit16),
        .o_csr_illegal(ill16), .o_pmpcfg(cfg16), .o_pmpaddr(paddr16)
    );

    pmp_csr #(.PMP_REGIONS(8)) dut8 (
        .i_clk(clk), .i_rst(rst_n), .i_csr_valid(valid), .i_csr_addr(addr),
        .i_csr_op(op), .i_csr_wdata(wdata), .i_priv_mode(priv),
        .o_csr_rdata(rdata8), .o_csr_rvalid(rvalid8), .o_csr_hit(hit8),
        .o_csr_illegal(ill8), .o_pmpcfg(cfg8), .o_pmpaddr(paddr8)
    );

    task automatic do_reset();
        valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) begin
                mcfg[d][i]  = 8'h00;
                maddr[d][i] = 32'h0;
            end
    endtask

    // drive one access; returns 1ns after the edge that takes it
    task automatic do_access(input logic [1:0] o, input logic [11:0] a,
                             input logic [31:0] d, input logic [1:0] p);
        op = o; addr = a; wdata = d; priv = p; valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_idle();
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_old(input int d, input logic [11:0] a);
        logic [31:0] v;
        int i;
        v = 32'h0;
        if (a >= 12'h3A0 && a <= 12'h3A3) begin
            for (int k = 0; k < 4; k++) begin
                i = 4 * (int'(a) - 'h3A0) + k;
                if (i < nreg[d]) v[8*k +: 8] = mcfg[d][i];
            end
        end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            i = int'(a) - 'h3B0;
            if (i < nreg[d]) v = maddr[d][i];
        end
        return v;
    endfunction

    function automatic bit m_hit(input logic [11:0] a);
        return (a >= 12'h3A0 && a <= 12'h3A3) || (a >= 12'h3B0 && a <= 12'h3BF);
    endfunction

    task automatic m_write(input int d, input logic [1:0] o, input logic [11:0] a,
                           input logic [31:0] w, input logic [1:0] p);
        logic [31:0] nv;
        logic [7:0]  b;
        int          i;
        if (!m_hit(a) || p != m_mode || o == 2'd0 || (o != 2'd1 && w == 32'h0)) return;
        nv = (o == 2'd1) ? w : (o == 2'd2) ? (m_old(d, a) | w) : (m_old(d, a) & ~w);
        if (a <= 12'h3A3) begin
            for (int k = 0; k < 4; k++) begin
                i = 4 * (int'(a) - 'h3A0) + k;
                if (i < nreg[d] && !mcfg[d][i][7]) begin
                    b = nv[8*k +: 8] & 8'h9F;
                    if (b[1:0] == 2'b10) b[1] = 1'b0;
                    mcfg[d][i] = b;
                end
            end
        end else begin
            i = int'(a) - 'h3B0;
            if (i < nreg[d] && !mcfg[d][i][7] &&
                !(i + 1 < nreg[d] && mcfg[d][i+1][7] && mcfg[d][i+1][4:3] == 2'b01))
                maddr[d][i] = nv;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rdata16 !== 32'h0 || rvalid16 !== 1'b0 || hit16 !== 1'b0 || ill16 !== 1'b0) begin
            n_errors++; $display("FAIL reset_outputs: got rdata=%h rvalid=%b hit=%b ill=%b want 0", rdata16, rvalid16, hit16, ill16); end
        n_checks++; if (cfg16 !== '0 || paddr16 !== '0) begin
            n_errors++; $display("FAIL reset_regs: got cfg=%h addr=%h want 0", cfg16, paddr16); end
        do_access(CSR_READ, 12'h3A0, 32'h0, m_mode);
        n_checks++; if (rvalid16 !== 1'b1 || hit16 !== 1'b1 || rdata16 !== 32'h0) begin
            n_errors++; $display("FAIL reset_read_3a0: got rvalid=%b hit=%b rdata=%h want 1 1 0", rvalid16, hit16, rdata16); end
        do_access(CSR_READ, 12'h3B5, 32'h0, m_mode);
        n_checks++; if (rvalid16 !== 1'b1 || hit16 !== 1'b1 || rdata16 !== 32'h0) begin
            n_errors++; $display("FAIL reset_read_3b5: got rvalid=%b hit=%b rdata=%h want 1 1 0", rvalid16, hit16, rdata16); end
        do_idle();
        n_checks++; if (rvalid16 !== 1'b0 || hit16 !== 1'b0) begin
            n_errors++; $display("FAIL rvalid_pulse: got rvalid=%b hit=%b want 0 0", rvalid16, hit16); end
    endtask

    task automatic test_cfg_warl();
        do_reset();
        do_access(CSR_RW, 12'h3A0, 32'h8F0E0B03, m_mode);
        do_access(CSR_READ, 12'h3A0, 32'h0, m_mode);
        n_checks++; if (rdata16 !== 32'h8F0C0B03) begin
            n_errors++; $display("FAIL cfg_warl_read: got %h want %h", rdata16, 32'h8F0C0B03); end
        n_checks++; if (cfg16[3:0] !== 32'h8F0C0B03) begin
            n_errors++; $display("FAIL cfg_warl_out: got %h want %h", cfg16[3:0], 32'h8F0C0B03); end
        do_access(CSR_RC, 12'h3A0, 32'hFFFFFFFF, m_mode);
        do_access(CSR_READ, 12'h3A0, 32'h0, m_mode);
        n_checks++; if (rdata16 !== 32'h8F000000) begin
            n_errors++; $display("FAIL cfg_lock_clear: got %h want %h", rdata16, 32'h8F000000); end
        do_access(CSR_RW, 12'h3A1, 32'h60606060, m_mode);
        do_access(CSR_READ, 12'h3A1, 32'h0, m_mode);
        n_checks++; if (rdata16 !== 32'h0) begin
            n_errors++; $display("FAIL cfg_rsvd_clear: got %h want 0", rdata16); end
        do_idle();
    endtask

    task automatic test_addr_lock();
        do_reset();
        do_access(CSR_RW, 12'h3A0, 32'h00008800, m_mode);
        do_access(CSR_RW, 12'h3B0, 32'h1234, m_mode);
        do_access(CSR_RW, 12'h3B1, 32'h55, m_mode);
        do_access(CSR_RW, 12'h3B2, 32'h77, m_mode);
        do_idle();
        n_checks++; if (paddr16[0] !== 32'h0) begin
            n_errors++; $display("FAIL tor_lock_addr0: got %h want 0", paddr16[0]); end
        n_checks++; if (paddr16[1] !== 32'h0) begin
            n_errors++; $display("FAIL lock_addr1: got %h want 0", paddr16[1]); end
        n_checks++; if (paddr16[2] !== 32'h77) begin
            n_errors++; $display("FAIL unlocked_addr2: got %h want 77", paddr16[2]); end
    endtask

    task automatic test_priv();
        do_reset();
        do_access(CSR_RW, 12'h3B3, 32'hFFFF, u_mode);
        n_checks++; if (ill16 !== 1'b1 || hit16 !== 1'b1) begin
            n_errors++; $display("FAIL priv_illegal: got ill=%b hit=%b want 1 1", ill16, hit16); end
        n_checks++; if (paddr16[3] !== 32'h0) begin
            n_errors++; $display("FAIL priv_nowrite: got %h want 0", paddr16[3]); end
        do_access(CSR_RW, 12'h3B3, 32'hFFFF, m_mode);
        n_checks++; if (ill16 !== 1'b0 || paddr16[3] !== 32'hFFFF) begin
            n_errors++; $display("FAIL priv_mwrite: got ill=%b addr3=%h want 0 ffff", ill16, paddr16[3]); end
        do_idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_access(CSR_RW, 12'h3B4, 32'hA, m_mode);
        n_checks++; if (rvalid16 !== 1'b1 || rdata16 !== 32'h0) begin
            n_errors++; $display("FAIL b2b_old_value: got rvalid=%b rdata=%h want 1 0", rvalid16, rdata16); end
        do_access(CSR_READ, 12'h3B4, 32'h0, m_mode);
        n_checks++; if (rvalid16 !== 1'b1 || rdata16 !== 32'hA) begin
            n_errors++; $display("FAIL b2b_read: got rvalid=%b rdata=%h want 1 a", rvalid16, rdata16); end
        do_access(CSR_RS, 12'h3B4, 32'h0, m_mode);
        do_access(CSR_RS, 12'h3B4, 32'h5, m_mode);
        do_access(CSR_READ, 12'h3B4, 32'h0, m_mode);
        n_checks++; if (rdata16 !== 32'hF) begin
            n_errors++; $display("FAIL b2b_set: got %h want f", rdata16); end
        do_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        op = CSR_RW; addr = 12'h3B6; wdata = 32'h99; priv = m_mode; valid = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (paddr16[6] !== 32'h0 || rvalid16 !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid: got addr6=%h rvalid=%b want 0 0", paddr16[6], rvalid16); end
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_regions8();
        do_reset();
        do_access(CSR_RW, 12'h3BF, 32'h1, m_mode);
        do_access(CSR_READ, 12'h3BF, 32'h0, m_mode);
        n_checks++; if (rdata8 !== 32'h0 || paddr8 !== '0) begin
            n_errors++; $display("FAIL r8_unimpl_addr: got rdata=%h addr=%h want 0", rdata8, paddr8); end
        n_checks++; if (rdata16 !== 32'h1) begin
            n_errors++; $display("FAIL r16_addr15: got %h want 1", rdata16); end
        do_access(CSR_RW, 12'h3A2, 32'h00000088, m_mode);
        do_access(CSR_RW, 12'h3B7, 32'h5, m_mode);
        do_access(CSR_READ, 12'h3A2, 32'h0, m_mode);
        n_checks++; if (rdata8 !== 32'h0 || rdata16 !== 32'h88) begin
            n_errors++; $display("FAIL r8_unimpl_cfg: got r8=%h r16=%h want 0 88", rdata8, rdata16); end
        n_checks++; if (paddr8[7] !== 32'h5 || paddr16[7] !== 32'h0) begin
            n_errors++; $display("FAIL last_region_tor: got r8=%h r16=%h want 5 0", paddr8[7], paddr16[7]); end
        do_idle();
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [1:0]  o, p;
        logic [31:0] w;
        logic [31:0] exp_rd [2];
        logic [31:0] gr;
        logic        gh, gi, gv;
        int          r;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            r = $urandom % 24;
            a = (r < 4) ? 12'(12'h3A0 + r) : (r < 20) ? 12'(12'h3B0 + r - 4) : 12'(12'h3C0 + r);
            o = 2'($urandom % 4);
            w = $urandom;
            if ($urandom % 8 != 0) w = w & 32'h7F7F7F7F;
            if ($urandom % 6 == 0) w = 32'h0;
            p = ($urandom % 8 == 0) ? u_mode : m_mode;
            for (int d = 0; d < 2; d++) exp_rd[d] = m_old(d, a);
            do_access(o, a, w, p);
            for (int d = 0; d < 2; d++) begin
                gr = (d == 0) ? rdata16 : rdata8;
                gh = (d == 0) ? hit16 : hit8;
                gi = (d == 0) ? ill16 : ill8;
                gv = (d == 0) ? rvalid16 : rvalid8;
                n_checks++; if (gv !== 1'b1 || gh !== m_hit(a) || gi !== (m_hit(a) && p != m_mode)) begin
                    n_errors++; $display("FAIL rnd_status d%0d a=%h: got v=%b h=%b i=%b", d, a, gv, gh, gi); end
                if (p == m_mode) begin
                    n_checks++; if (gr !== (m_hit(a) ? exp_rd[d] : 32'h0)) begin
                        n_errors++; $display("FAIL rnd_rdata d%0d a=%h: got %h want %h", d, a, gr, m_hit(a) ? exp_rd[d] : 32'h0); end
                end
                m_write(d, o, a, w, p);
                for (int i = 0; i < nreg[d]; i++) begin
                    n_checks++;
                    if (((d == 0) ? cfg16[i] : cfg8[i % 8]) !== mcfg[d][i] ||
                        ((d == 0) ? paddr16[i] : paddr8[i % 8]) !== maddr[d][i]) begin
                        n_errors++;
                        $display("FAIL rnd_state d%0d region %0d: got cfg=%h addr=%h want cfg=%h addr=%h", d, i,
                                 (d == 0) ? cfg16[i] : cfg8[i % 8], (d == 0) ? paddr16[i] : paddr8[i % 8], mcfg[d][i], maddr[d][i]);
                    end
                end
            end
            if ($urandom % 5 == 0) do_idle();
            if ($urandom % 100 == 0) do_reset();
        end
        do_idle();
    endtask

    initial begin
        test_reset();
        test_cfg_warl();
        test_addr_lock();
        test_priv();
        test_back_to_back();
        test_reset_mid();
        test_regions8();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
